// File: rtl/exe_operand_stage_if.sv
// exe_operand_stage_if: the ID/EX stage's bus bundle.
//   master : the surrounding pipeline. It drives the ID fields, the stall and
//            flush controls and the MEM/WB forwarding buses. It receives the
//            EX-stage outputs.
//   slave  : exe_operand_stage itself.
interface exe_operand_stage_if;
  // ID-stage instruction fields
  logic        id_valid;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [15:0] id_imm;
  logic        id_imm_sext;
  logic [4:0]  id_shamt;
  logic [1:0]  id_a_src;
  logic        id_b_src;
  logic [3:0]  id_alu_oper;
  logic        id_alu_sign;
  logic        id_wb_en;
  logic [4:0]  id_wb_addr;
  logic        id_mem_ren;
  logic        id_mem_wen;
  // pipeline control
  logic        stall_in;
  logic        flush;
  // MEM-stage producer
  logic        mem_wb_en;
  logic [4:0]  mem_wb_addr;
  logic        mem_is_load;
  logic [31:0] mem_result;
  // WB-stage producer
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  // EX-stage outputs
  logic        exe_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_oper;
  logic        alu_sign;
  logic [31:0] exe_store_data;
  logic        exe_wb_en;
  logic [4:0]  exe_wb_addr;
  logic        exe_mem_ren;
  logic        exe_mem_wen;
  logic        load_use_stall;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
           id_imm_sext, id_shamt, id_a_src, id_b_src, id_alu_oper, id_alu_sign,
           id_wb_en, id_wb_addr, id_mem_ren, id_mem_wen, stall_in, flush,
           mem_wb_en, mem_wb_addr, mem_is_load, mem_result, wb_en, wb_addr, wb_data,
    input  exe_valid, alu_a, alu_b, alu_oper, alu_sign, exe_store_data,
           exe_wb_en, exe_wb_addr, exe_mem_ren, exe_mem_wen, load_use_stall
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
           id_imm_sext, id_shamt, id_a_src, id_b_src, id_alu_oper, id_alu_sign,
           id_wb_en, id_wb_addr, id_mem_ren, id_mem_wen, stall_in, flush,
           mem_wb_en, mem_wb_addr, mem_is_load, mem_result, wb_en, wb_addr, wb_data,
    output exe_valid, alu_a, alu_b, alu_oper, alu_sign, exe_store_data,
           exe_wb_en, exe_wb_addr, exe_mem_ren, exe_mem_wen, load_use_stall
  );
endinterface

// File: rtl/exe_operand_stage.sv
// exe_operand_stage: ID/EX pipeline register in front of the ALU.
// It registers the decoded fields and forwards rs/rt from MEM (non-load)
// or WB, with MEM taking priority. It builds the ALU a/b operands and detects
// load-use hazards, for which it inserts a bubble.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of exe_operand_stage_if. It carries the ID fields,
//           stall_in/flush, the MEM/WB forwarding buses and all EX outputs.
module exe_operand_stage (
  input  logic                 clk,
  input  logic                 rst_n,
  exe_operand_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    A_RS    = 2'b00,
    A_SHAMT = 2'b01,
    A_RS_LO = 2'b10,
    A_ZERO  = 2'b11
  } a_src_e;

  logic        valid_q;
  logic [4:0]  rs_addr_q;
  logic [4:0]  rt_addr_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;
  logic [31:0] imm_ext_q;
  logic [4:0]  shamt_q;
  a_src_e      a_src_q;
  logic        b_src_q;
  logic [3:0]  oper_q;
  logic        sign_q;
  logic        wb_en_q;
  logic [4:0]  wb_addr_q;
  logic        mem_ren_q;
  logic        mem_wen_q;

  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic        rs_used;
  logic        rt_used;
  logic        lu_stall;

  // r0 is never forwarded. MEM results of loads are not ready yet, so they
  // are skipped here and the load-use bubble covers that case.
  function automatic logic [31:0] forward(
    input logic [4:0]  addr,
    input logic [31:0] held,
    input logic        m_en,
    input logic        m_load,
    input logic [4:0]  m_addr,
    input logic [31:0] m_data,
    input logic        w_en,
    input logic [4:0]  w_addr,
    input logic [31:0] w_data
  );
    logic [31:0] v;
    v = held;
    if (addr != '0) begin
      if (m_en && !m_load && (m_addr == addr))
        v = m_data;
      else if (w_en && (w_addr == addr))
        v = w_data;
    end
    return v;
  endfunction

  always_comb begin
    fwd_rs = forward(rs_addr_q, rs_data_q, bus.mem_wb_en, bus.mem_is_load,
                     bus.mem_wb_addr, bus.mem_result, bus.wb_en, bus.wb_addr,
                     bus.wb_data);
    fwd_rt = forward(rt_addr_q, rt_data_q, bus.mem_wb_en, bus.mem_is_load,
                     bus.mem_wb_addr, bus.mem_result, bus.wb_en, bus.wb_addr,
                     bus.wb_data);
  end

  always_comb begin
    rs_used  = (bus.id_a_src == A_RS) || (bus.id_a_src == A_RS_LO);
    rt_used  = !bus.id_b_src || bus.id_mem_wen;
    lu_stall = valid_q && mem_ren_q && wb_en_q && (wb_addr_q != '0) &&
               bus.id_valid &&
               ((rs_used && (bus.id_rs_addr == wb_addr_q)) ||
                (rt_used && (bus.id_rt_addr == wb_addr_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_ext_q <= '0;
      shamt_q   <= '0;
      a_src_q   <= A_RS;
      b_src_q   <= 1'b0;
      oper_q    <= '0;
      sign_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (bus.stall_in) begin
      // Refresh the operand data so that a producer retiring from WB during
      // the stall is kept after it leaves the forwarding bus.
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
    end else if (lu_stall) begin
      valid_q <= 1'b0;
    end else begin
      valid_q   <= bus.id_valid;
      rs_addr_q <= bus.id_rs_addr;
      rt_addr_q <= bus.id_rt_addr;
      rs_data_q <= bus.id_rs_data;
      rt_data_q <= bus.id_rt_data;
      imm_ext_q <= bus.id_imm_sext ? {{16{bus.id_imm[15]}}, bus.id_imm}
                                   : {16'b0, bus.id_imm};
      shamt_q   <= bus.id_shamt;
      a_src_q   <= a_src_e'(bus.id_a_src);
      b_src_q   <= bus.id_b_src;
      oper_q    <= bus.id_alu_oper;
      sign_q    <= bus.id_alu_sign;
      wb_en_q   <= bus.id_wb_en;
      wb_addr_q <= bus.id_wb_addr;
      mem_ren_q <= bus.id_mem_ren;
      mem_wen_q <= bus.id_mem_wen;
    end
  end

  always_comb begin
    unique case (a_src_q)
      A_RS:    bus.alu_a = fwd_rs;
      A_SHAMT: bus.alu_a = {27'b0, shamt_q};
      A_RS_LO: bus.alu_a = {27'b0, fwd_rs[4:0]};
      default: bus.alu_a = '0;
    endcase
    bus.alu_b          = b_src_q ? imm_ext_q : fwd_rt;
    bus.exe_store_data = fwd_rt;
    bus.alu_oper       = oper_q;
    bus.alu_sign       = sign_q;
    bus.exe_valid      = valid_q;
    bus.exe_wb_en      = valid_q && wb_en_q;
    bus.exe_wb_addr    = wb_addr_q;
    bus.exe_mem_ren    = valid_q && mem_ren_q;
    bus.exe_mem_wen    = valid_q && mem_wen_q;
    bus.load_use_stall = lu_stall;
  end

endmodule

// File: tb/tb_exe_operand_stage.sv
// Testbench for exe_operand_stage: directed scenarios followed by randomized
// traffic checked against an instruction-level reference model.
module tb_exe_operand_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  exe_operand_stage_if bus ();

  exe_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference view of the instruction currently held in EX.
  typedef struct {
    bit        valid;
    bit [4:0]  rs, rt;
    bit [31:0] rs_val, rt_val, imm;
    bit [4:0]  shamt;
    bit [1:0]  a_src;
    bit        b_src;
    bit [3:0]  oper;
    bit        sign;
    bit        wb_en;
    bit [4:0]  wb_addr;
    bit        ld, st;
  } ex_t;

  ex_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_imm_sext = 0;
    bus.id_shamt = 0; bus.id_a_src = 0; bus.id_b_src = 0; bus.id_alu_oper = 0;
    bus.id_alu_sign = 0; bus.id_wb_en = 0; bus.id_wb_addr = 0;
    bus.id_mem_ren = 0; bus.id_mem_wen = 0; bus.stall_in = 0; bus.flush = 0;
    bus.mem_wb_en = 0; bus.mem_wb_addr = 0; bus.mem_is_load = 0; bus.mem_result = 0;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Newest value of a register: MEM (non-load) first, then WB, else held.
  function automatic bit [31:0] latest(input bit [4:0] r, input bit [31:0] held);
    if (r == 0) return held;
    if (bus.mem_wb_en && !bus.mem_is_load && bus.mem_wb_addr == r) return bus.mem_result;
    if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
    return held;
  endfunction

  function automatic bit exp_hazard();
    bit reads_rs, reads_rt;
    reads_rs = (bus.id_a_src == 2'd0) || (bus.id_a_src == 2'd2);
    reads_rt = (bus.id_b_src == 1'b0) || bus.id_mem_wen;
    return m.valid && m.ld && m.wb_en && m.wb_addr != 0 && bus.id_valid &&
           ((reads_rs && bus.id_rs_addr == m.wb_addr) ||
            (reads_rt && bus.id_rt_addr == m.wb_addr));
  endfunction

  function automatic bit [31:0] exp_a();
    bit [31:0] rs_now;
    rs_now = latest(m.rs, m.rs_val);
    case (m.a_src)
      2'd0:    return rs_now;
      2'd1:    return 32'(m.shamt);
      2'd2:    return rs_now % 32;
      default: return 0;
    endcase
  endfunction

  initial begin
    bit hz;
    clear_inputs();

    // Reset state
    #2;
    chk("rst_valid", 32'(bus.exe_valid), 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_store", bus.exe_store_data, 0);
    chk("rst_lus",   32'(bus.load_use_stall), 0);
    #10 rst_n = 1;
    tick();

    // Forward priority: rs=5, MEM 0x11 beats WB 0x22
    bus.id_valid = 1; bus.id_rs_addr = 5; bus.id_rs_data = 32'h99;
    bus.id_b_src = 1; bus.id_imm = 16'h0010; bus.id_alu_oper = 4'd2;
    tick();
    bus.id_valid = 0;
    bus.mem_wb_en = 1; bus.mem_wb_addr = 5; bus.mem_result = 32'h11;
    bus.wb_en = 1; bus.wb_addr = 5; bus.wb_data = 32'h22;
    #1 chk("fwd_mem", bus.alu_a, 32'h11);
    chk("fwd_imm_zext", bus.alu_b, 32'h10);
    chk("fwd_oper", 32'(bus.alu_oper), 2);
    bus.mem_wb_en = 0;
    #1 chk("fwd_wb", bus.alu_a, 32'h22);
    bus.mem_wb_en = 1; bus.mem_is_load = 1;
    #1 chk("fwd_skip_load", bus.alu_a, 32'h22);
    clear_inputs();
    #1 chk("fwd_none", bus.alu_a, 32'h99);

    // r0 guard
    bus.id_valid = 1;
    tick();
    bus.mem_wb_en = 1; bus.mem_wb_addr = 0; bus.mem_result = '1;
    bus.wb_en = 1; bus.wb_addr = 0; bus.wb_data = '1;
    #1 chk("r0_guard", bus.alu_a, 0);
    clear_inputs();

    // Load-use: lw r3 in EX, addi r4,r3,-1 in ID
    bus.id_valid = 1; bus.id_rs_addr = 1; bus.id_b_src = 1;
    bus.id_mem_ren = 1; bus.id_wb_en = 1; bus.id_wb_addr = 3;
    tick();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs_addr = 3; bus.id_b_src = 1;
    bus.id_imm = 16'hFFFF; bus.id_imm_sext = 1; bus.id_wb_en = 1; bus.id_wb_addr = 4;
    #1 chk("lu_stall", 32'(bus.load_use_stall), 1);
    chk("lu_mem_ren", 32'(bus.exe_mem_ren), 1);
    tick();
    chk("lu_bubble", 32'(bus.exe_valid), 0);
    chk("lu_bubble_wb", 32'(bus.exe_wb_en), 0);
    chk("lu_once", 32'(bus.load_use_stall), 0);
    bus.mem_wb_en = 1; bus.mem_wb_addr = 3; bus.mem_is_load = 1;
    tick();
    bus.id_valid = 0; bus.mem_wb_en = 0; bus.mem_is_load = 0;
    bus.wb_en = 1; bus.wb_addr = 3; bus.wb_data = 7;
    #1 chk("lu_consumer_valid", 32'(bus.exe_valid), 1);
    chk("lu_alu_a", bus.alu_a, 7);
    chk("lu_alu_b_sext", bus.alu_b, 32'hFFFF_FFFF);
    chk("lu_wb_addr", 32'(bus.exe_wb_addr), 4);
    clear_inputs();

    // Shift operands
    bus.id_valid = 1; bus.id_a_src = 2'd1; bus.id_shamt = 4;
    tick();
    chk("shamt", bus.alu_a, 4);
    bus.id_a_src = 2'd2; bus.id_rs_addr = 6;
    tick();
    bus.wb_en = 1; bus.wb_addr = 6; bus.wb_data = 32'h25;
    #1 chk("var_shift", bus.alu_a, 5);
    clear_inputs();

    // Stall with a producer retiring from WB in the first stall cycle only
    bus.id_valid = 1; bus.id_rt_addr = 7; bus.id_b_src = 1; bus.id_mem_wen = 1;
    bus.id_wb_en = 1; bus.id_wb_addr = 9;
    tick();
    bus.id_rt_addr = 8; bus.id_rt_data = 32'h1234; bus.id_mem_wen = 0;
    bus.stall_in = 1; bus.wb_en = 1; bus.wb_addr = 7; bus.wb_data = 32'hABCD;
    #1 chk("stall_c1", bus.exe_store_data, 32'hABCD);
    tick();
    bus.wb_en = 0;
    #1 chk("stall_c2", bus.exe_store_data, 32'hABCD);
    chk("stall_hold_wen", 32'(bus.exe_mem_wen), 1);
    tick();
    chk("stall_c3", bus.exe_store_data, 32'hABCD);
    chk("stall_wb_en", 32'(bus.exe_wb_en), 1);

    // Flush wins over stall
    bus.flush = 1;
    tick();
    chk("flush_valid", 32'(bus.exe_valid), 0);
    chk("flush_wb_en", 32'(bus.exe_wb_en), 0);
    clear_inputs();

    // Asynchronous reset mid-cycle
    bus.id_valid = 1; bus.id_rs_addr = 2; bus.id_rs_data = 32'h55; bus.id_shamt = 3;
    bus.id_alu_oper = 4'hA; bus.id_alu_sign = 1; bus.id_wb_en = 1; bus.id_wb_addr = 2;
    tick();
    chk("pre_rst_valid", 32'(bus.exe_valid), 1);
    #2 rst_n = 0;
    #1 chk("arst_valid", 32'(bus.exe_valid), 0);
    chk("arst_alu_a", bus.alu_a, 0);
    chk("arst_oper", 32'(bus.alu_oper), 0);
    chk("arst_sign", 32'(bus.alu_sign), 0);
    chk("arst_wb", {26'b0, bus.exe_wb_en, bus.exe_wb_addr}, 0);
    clear_inputs();
    #3 rst_n = 1;
    m = '{default: 0};
    tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      bus.id_valid    = 1'($urandom_range(0, 3) != 0);
      bus.id_rs_addr  = 5'($urandom_range(0, 3));
      bus.id_rt_addr  = 5'($urandom_range(0, 3));
      bus.id_rs_data  = $urandom;
      bus.id_rt_data  = $urandom;
      bus.id_imm      = 16'($urandom);
      bus.id_imm_sext = 1'($urandom);
      bus.id_shamt    = 5'($urandom);
      bus.id_a_src    = 2'($urandom);
      bus.id_b_src    = 1'($urandom);
      bus.id_alu_oper = 4'($urandom);
      bus.id_alu_sign = 1'($urandom);
      bus.id_wb_en    = 1'($urandom);
      bus.id_wb_addr  = 5'($urandom_range(0, 3));
      bus.id_mem_ren  = 1'($urandom_range(0, 2) == 0);
      bus.id_mem_wen  = 1'($urandom_range(0, 3) == 0);
      bus.stall_in    = 1'($urandom_range(0, 7) == 0);
      bus.flush       = 1'($urandom_range(0, 11) == 0);
      bus.mem_wb_en   = 1'($urandom);
      bus.mem_wb_addr = 5'($urandom_range(0, 3));
      bus.mem_is_load = 1'($urandom);
      bus.mem_result  = $urandom;
      bus.wb_en       = 1'($urandom);
      bus.wb_addr     = 5'($urandom_range(0, 3));
      bus.wb_data     = $urandom;
      #1;
      hz = exp_hazard();
      chk("rnd_valid",   32'(bus.exe_valid), 32'(m.valid));
      chk("rnd_wb_en",   32'(bus.exe_wb_en), 32'(m.valid && m.wb_en));
      chk("rnd_mem_ren", 32'(bus.exe_mem_ren), 32'(m.valid && m.ld));
      chk("rnd_mem_wen", 32'(bus.exe_mem_wen), 32'(m.valid && m.st));
      chk("rnd_lus",     32'(bus.load_use_stall), 32'(hz));
      if (m.valid) begin
        chk("rnd_alu_a", bus.alu_a, exp_a());
        chk("rnd_alu_b", bus.alu_b, m.b_src ? m.imm : latest(m.rt, m.rt_val));
        chk("rnd_store", bus.exe_store_data, latest(m.rt, m.rt_val));
        chk("rnd_oper",  32'(bus.alu_oper), 32'(m.oper));
        chk("rnd_sign",  32'(bus.alu_sign), 32'(m.sign));
        chk("rnd_wb_addr", 32'(bus.exe_wb_addr), 32'(m.wb_addr));
      end
      @(posedge clk);
      if (bus.flush) begin
        m.valid = 0;
      end else if (bus.stall_in) begin
        m.rs_val = latest(m.rs, m.rs_val);
        m.rt_val = latest(m.rt, m.rt_val);
      end else if (hz) begin
        m.valid = 0;
      end else begin
        m.valid   = bus.id_valid;
        m.rs      = bus.id_rs_addr;
        m.rt      = bus.id_rt_addr;
        m.rs_val  = bus.id_rs_data;
        m.rt_val  = bus.id_rt_data;
        m.imm     = bus.id_imm_sext ? 32'(signed'(bus.id_imm)) : 32'(bus.id_imm);
        m.shamt   = bus.id_shamt;
        m.a_src   = bus.id_a_src;
        m.b_src   = bus.id_b_src;
        m.oper    = bus.id_alu_oper;
        m.sign    = bus.id_alu_sign;
        m.wb_en   = bus.id_wb_en;
        m.wb_addr = bus.id_wb_addr;
        m.ld      = bus.id_mem_ren;
        m.st      = bus.id_mem_wen;
      end
      #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
